nes_pad_emulator: RTL and testbench

NES_PAD_EMULATOR -- requirements
Module: nes_pad_emulator

---
 rtl/nes_pkg.sv | 22 ++
 rtl/sync_edge.sv | 33 +++
 rtl/nes_pad_emulator.sv | 179 +++++++++++++++++
 tb/tb_nes_pad_emulator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - button index constants and FSM state type for the NES pad emulator
// Ports: none (package).
package nes_pkg;

    // Bit positions of each button in the parallel load word and shift register
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } nes_pad_state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchronizer with registered-history rise/fall detection
// Ports: clk, rst (sync active-high), i_async (asynchronous input),
//        o_level (synchronized level), o_rise / o_fall (one-cycle edge pulses).
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/nes_pad_emulator.sv
// rtl/nes_pad_emulator.sv - NES controller (4021-style) serial pad emulator
// Ports: clk, rst (sync active-high); latch_in, pulse_in (async host strobes);
//        buttons_in[0:7] (A,B,Select,Start,Up,Down,Left,Right, 1=pressed);
//        turbo_in[0:1] (turbo enable for A/B); data_out (active-low serial);
//        bit_idx (bits shifted this frame, 0..8); frame_done (pulse on 8th bit).
// Build option: define NES_PAD_TURBO_EN to enable the A/B turbo masking.
module nes_pad_emulator
    import nes_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = 24'd600000,
    parameter int          TURBO_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       latch_in,
    input  logic       pulse_in,
    input  logic [0:7] buttons_in,
    input  logic [0:1] turbo_in,
    output logic       data_out,
    output logic [3:0] bit_idx,
    output logic       frame_done
);

    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYC - 24'd1;

    nes_pad_state_t r_state;
    nes_pad_state_t w_next_state;

    logic [7:0]  r_shreg;
    logic [3:0]  r_bit_idx;
    logic        r_frame_done;
    logic [23:0] r_timeout;

    logic [7:0]  w_load_val;
    logic        w_shift;
    logic        w_done;

    logic w_latch_lvl;
    logic w_latch_rise;
    logic w_latch_fall;
    logic w_pulse_rise;
    logic w_unused_pulse_lvl;
    logic w_unused_pulse_fall;

    sync_edge u_latch_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (latch_in),
        .o_level (w_latch_lvl),
        .o_rise  (w_latch_rise),
        .o_fall  (w_latch_fall)
    );

    sync_edge u_pulse_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pulse_in),
        .o_level (w_unused_pulse_lvl),
        .o_rise  (w_pulse_rise),
        .o_fall  (w_unused_pulse_fall)
    );

`ifdef NES_PAD_TURBO_EN
    localparam logic [7:0] TURBO_LAST = 8'(TURBO_DIV - 1);

    logic [7:0] r_turbo_cnt;
    logic       r_turbo_phase;

    // The phase advances once every TURBO_DIV host frames (counted on latch release)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_turbo_cnt   <= 8'd0;
            r_turbo_phase <= 1'b0;
        end else if (w_latch_fall) begin
            if (r_turbo_cnt >= TURBO_LAST) begin
                r_turbo_cnt   <= 8'd0;
                r_turbo_phase <= ~r_turbo_phase;
            end else begin
                r_turbo_cnt <= r_turbo_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        // buttons_in is ascending ([0:7]); shreg is descending with A at bit 0
        w_load_val = {buttons_in[7], buttons_in[6], buttons_in[5], buttons_in[4],
                      buttons_in[3], buttons_in[2], buttons_in[1], buttons_in[0]};
        if (!r_turbo_phase) begin
            if (turbo_in[0]) w_load_val[BTN_A] = 1'b0;
            if (turbo_in[1]) w_load_val[BTN_B] = 1'b0;
        end
    end
`else
    logic w_unused_turbo;
    assign w_unused_turbo = ^{turbo_in, 8'(TURBO_DIV)};

    always_comb begin
        w_load_val = {buttons_in[7], buttons_in[6], buttons_in[5], buttons_in[4],
                      buttons_in[3], buttons_in[2], buttons_in[1], buttons_in[0]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // A latch rising edge beats everything else, including a coincident pulse edge
    always_comb begin
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        if (w_latch_rise) begin
            w_next_state = LOAD;
        end else begin
            case (r_state)
                IDLE:  if (w_latch_lvl) w_next_state = LOAD;
                LOAD:  if (w_latch_fall) w_next_state = SHIFT;
                SHIFT: begin
                    if (w_pulse_rise) begin
                        w_shift = 1'b1;
                        if (r_bit_idx == 4'd7) begin
                            w_done       = 1'b1;
                            w_next_state = DRAIN;
                        end
                    end else if (r_timeout >= TIMEOUT_LAST) begin
                        w_next_state = IDLE;
                    end
                end
                DRAIN:   w_next_state = DRAIN;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg      <= 8'h00;
            r_bit_idx    <= 4'd0;
            r_frame_done <= 1'b0;
            r_timeout    <= 24'd0;
        end else begin
            r_frame_done <= w_done;

            // Loading on every cycle headed into LOAD keeps shreg tracking the buttons
            if (w_next_state == LOAD) begin
                r_shreg   <= w_load_val;
                r_bit_idx <= 4'd0;
            end else if (w_shift) begin
                r_shreg   <= {1'b1, r_shreg[7:1]};
                r_bit_idx <= r_bit_idx + 4'd1;
            end else if (w_next_state == IDLE) begin
                r_bit_idx <= 4'd0;
            end

            // Idle counter only runs while waiting for the next shift pulse
            if (r_state != SHIFT || w_latch_rise || w_latch_fall || w_pulse_rise) begin
                r_timeout <= 24'd0;
            end else if (r_timeout != 24'hFF_FFFF) begin
                r_timeout <= r_timeout + 24'd1;
            end
        end
    end

    always_comb begin
        data_out = 1'b1;
        case (r_state)
            IDLE:    data_out = 1'b1;
            LOAD:    data_out = ~r_shreg[BTN_A];
            SHIFT:   data_out = ~r_shreg[BTN_A];
            DRAIN:   data_out = 1'b0;
            default: data_out = 1'b1;
        endcase
    end

    assign bit_idx    = r_bit_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// tb/tb_nes_pad_emulator.sv - self-checking bench for nes_pad_emulator
module tb_nes_pad_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       latch_in;
    logic       pulse_in;
    logic [0:7] buttons_in;
    logic [0:1] turbo_in;
    logic       data_out;
    logic [3:0] bit_idx;
    logic       frame_done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    nes_pad_emulator #(
        .TIMEOUT_CYC (24'd100),
        .TURBO_DIV   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .latch_in   (latch_in),
        .pulse_in   (pulse_in),
        .buttons_in (buttons_in),
        .turbo_in   (turbo_in),
        .data_out   (data_out),
        .bit_idx    (bit_idx),
        .frame_done (frame_done)
    );

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch(input int w);
        latch_in = 1'b1;
        tick(w);
        latch_in = 1'b0;
        tick(4);
    endtask

    task automatic do_pulse();
        pulse_in = 1'b1;
        tick(4);
        pulse_in = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b1; latch_in = 1'b0; pulse_in = 1'b0; buttons_in = 8'h00; turbo_in = 2'b00;
        tick(3);
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL reset_data_out: got %b expected 1", data_out); end
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL reset_bit_idx: got %0d expected 0", bit_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        tick(3);
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL idle_data_out: got %b expected 1", data_out); end
    endtask

    task automatic test_frame();
        logic [0:7] btn;
        logic e;
        int d0;
        btn = 8'b0001_0000;
        buttons_in = btn;
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) exp_q.push_back(~btn[k]);
        do_latch(12);
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            checks++; if (data_out !== e) begin errors++; $display("FAIL frame_bit%0d: got %b expected %b", k, data_out, e); end
            checks++; if (bit_idx !== 4'(k)) begin errors++; $display("FAIL frame_idx%0d: got %0d expected %0d", k, bit_idx, k); end
            if (k == 7) begin
                checks++; if (done_cnt !== d0) begin errors++; $display("FAIL frame_done_early: got %0d expected %0d", done_cnt - d0, 0); end
            end
            do_pulse();
        end
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (bit_idx !== 4'd8) begin errors++; $display("FAIL frame_end_idx: got %0d expected 8", bit_idx); end
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL frame_end_data: got %b expected 0", data_out); end
    endtask

    task automatic test_drain();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            do_pulse();
            checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL drain_data%0d: got %b expected 0", k, data_out); end
            checks++; if (bit_idx !== 4'd8) begin errors++; $display("FAIL drain_idx%0d: got %0d expected 8", k, bit_idx); end
        end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL drain_done: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_abort();
        logic [0:7] btn;
        int d0;
        btn = 8'b1000_0000;
        buttons_in = btn;
        d0 = done_cnt;
        do_latch(6);
        for (int k = 0; k < 3; k++) do_pulse();
        checks++; if (bit_idx !== 4'd3) begin errors++; $display("FAIL abort_pre_idx: got %0d expected 3", bit_idx); end
        checks++; if (data_out !== ~btn[3]) begin errors++; $display("FAIL abort_pre_data: got %b expected %b", data_out, ~btn[3]); end
        // latch and pulse edges arrive together; latch must win
        latch_in = 1'b1;
        pulse_in = 1'b1;
        tick(2);
        checks++; if (bit_idx !== 4'd3) begin errors++; $display("FAIL abort_latency_idx: got %0d expected 3", bit_idx); end
        tick(1);
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL abort_idx: got %0d expected 0", bit_idx); end
        checks++; if (data_out !== ~btn[0]) begin errors++; $display("FAIL abort_data: got %b expected %b", data_out, ~btn[0]); end
        tick(1);
        pulse_in = 1'b0;
        tick(6);
        latch_in = 1'b0;
        tick(4);
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL abort_post_idx: got %0d expected 0", bit_idx); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_timeout();
        buttons_in = 8'hFF;
        do_latch(6);
        do_pulse();
        pulse_in = 1'b1;
        tick(3);
        checks++; if (bit_idx !== 4'd2) begin errors++; $display("FAIL timeout_idx: got %0d expected 2", bit_idx); end
        tick(1);
        pulse_in = 1'b0;
        tick(98);
        checks++; if (bit_idx !== 4'd2) begin errors++; $display("FAIL timeout_early_idx: got %0d expected 2", bit_idx); end
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL timeout_early_data: got %b expected 0", data_out); end
        tick(1);
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL timeout_idle_idx: got %0d expected 0", bit_idx); end
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL timeout_idle_data: got %b expected 1", data_out); end
        do_pulse();
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL timeout_ignore_idx: got %0d expected 0", bit_idx); end
    endtask

    task automatic test_reset_mid();
        logic [0:7] btn;
        btn = 8'b0110_1001;
        buttons_in = btn;
        do_latch(6);
        for (int k = 0; k < 4; k++) do_pulse();
        checks++; if (data_out !== ~btn[4]) begin errors++; $display("FAIL rstmid_pre_data: got %b expected %b", data_out, ~btn[4]); end
        pulse_in = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL rstmid_idx: got %0d expected 0", bit_idx); end
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL rstmid_data: got %b expected 1", data_out); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", frame_done); end
        tick(3);
        pulse_in = 1'b0;
        tick(4);
        for (int k = 0; k < 3; k++) do_pulse();
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL rstmid_ignore_idx: got %0d expected 0", bit_idx); end
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL rstmid_ignore_data: got %b expected 1", data_out); end
        do_latch(6);
        checks++; if (data_out !== ~btn[0]) begin errors++; $display("FAIL rstmid_relatch_data: got %b expected %b", data_out, ~btn[0]); end
    endtask

    task automatic test_back_to_back();
        logic [0:7] btn;
        logic e;
        int d0;
        for (int f = 0; f < 3; f++) begin
            btn = 8'($urandom);
            buttons_in = btn;
            d0 = done_cnt;
            for (int k = 0; k < 8; k++) exp_q.push_back(~btn[k]);
            do_latch(5);
            for (int k = 0; k < 8; k++) begin
                e = exp_q.pop_front();
                checks++; if (data_out !== e) begin errors++; $display("FAIL b2b_f%0d_bit%0d: got %b expected %b", f, k, data_out, e); end
                do_pulse();
            end
            checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL b2b_f%0d_done: got %0d expected 1", f, done_cnt - d0); end
            checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL b2b_f%0d_drain: got %b expected 0", f, data_out); end
        end
    endtask

`ifdef NES_PAD_TURBO_EN
    task automatic test_turbo();
        logic phase;
        logic e;
        int cnt;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        buttons_in = 8'b1000_0000;
        turbo_in = 2'b10;
        phase = 1'b0;
        cnt = 0;
        for (int f = 0; f < 8; f++) begin
            exp_q.push_back(phase);
            cnt++;
            if (cnt == 2) begin cnt = 0; phase = ~phase; end
        end
        for (int f = 0; f < 8; f++) begin
            do_latch(6);
            e = exp_q.pop_front();
            checks++; if (~data_out !== e) begin errors++; $display("FAIL turbo_f%0d: got %b expected %b", f, ~data_out, e); end
            tick(2);
        end
        turbo_in = 2'b00;
    endtask
`else
    task automatic test_turbo();
        buttons_in = 8'b1100_0000;
        turbo_in = 2'b11;
        for (int f = 0; f < 4; f++) begin
            do_latch(6);
            checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL noturbo_f%0d_a: got %b expected 0", f, data_out); end
            do_pulse();
            checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL noturbo_f%0d_b: got %b expected 0", f, data_out); end
        end
        turbo_in = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_drain();
        test_abort();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_turbo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
